// File: rtl/cv_bus_term_filt.sv
// Bus-terminated OR with supply sequencing, glitch filter and event counting.
// The OR of the enabled input bits is passed to `out` only after the supply
// has been good for SETTLE_CYC cycles and the new value has persisted for
// FILT_CNT consecutive edges. A supply drop forces everything back to idle.
module cv_bus_term_filt #(
  parameter int WIDTH      = 2,
  parameter int FILT_CNT   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int EVT_W      = 8,
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VDD,
  input  logic             VSS,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] en_mask,
  input  logic             evt_clr,
  output logic             out,
  output logic             ready,
  output logic [IDX_W-1:0] hi_idx,
  output logic             hit,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam int FC_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [FC_W-1:0] FILT_LAST   = FC_W'(FILT_CNT - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;

  logic [1:0]       state;
  logic [SC_W-1:0]  settle_cnt;
  logic [FC_W-1:0]  filt_cnt;
  logic [WIDTH-1:0] act;
  logic             raw;
  logic             sup_ok;
  logic             toggle;

  // Highest set bit of the active vector; 0 when nothing is set.
  function automatic logic [IDX_W-1:0] top_idx(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign act    = in & en_mask;
  assign raw    = |act;
  assign sup_ok = VDD & ~VSS;
  assign ready  = (state == S_ON);

  // A toggle is the filter committing a new value while running normally.
  assign toggle = ~rst & sup_ok & (state == S_ON) & (raw != out) &
                  (filt_cnt == FILT_LAST);

  // Supply sequencing, glitch filter and registered hit/index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      settle_cnt <= '0;
      filt_cnt   <= '0;
      out        <= 1'b0;
      hit        <= 1'b0;
      hi_idx     <= '0;
    end else if (!sup_ok) begin
      state      <= S_OFF;
      settle_cnt <= '0;
      filt_cnt   <= '0;
      out        <= 1'b0;
      hit        <= 1'b0;
      hi_idx     <= '0;
    end else begin
      case (state)
        S_OFF: begin
          state      <= S_SETTLE;
          settle_cnt <= '0;
          filt_cnt   <= '0;
          out        <= 1'b0;
          hit        <= 1'b0;
          hi_idx     <= '0;
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S_ON;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_ON: begin
          hit    <= raw;
          hi_idx <= top_idx(act);
          if (raw != out) begin
            if (filt_cnt == FILT_LAST) begin
              out      <= raw;
              filt_cnt <= '0;
            end else begin
              filt_cnt <= filt_cnt + 1'b1;
            end
          end else begin
            filt_cnt <= '0;
          end
        end
        default: begin
          state      <= S_OFF;
          settle_cnt <= '0;
          filt_cnt   <= '0;
          out        <= 1'b0;
          hit        <= 1'b0;
          hi_idx     <= '0;
        end
      endcase
    end
  end

  // Saturating transition counter; a clear wins over a same-edge toggle,
  // and a supply drop leaves the count untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_cnt <= '0;
    end else if (evt_clr) begin
      evt_cnt <= '0;
    end else if (toggle) begin
      evt_cnt <= sat_inc(evt_cnt);
    end
  end

endmodule

// File: tb/tb_cv_bus_term_filt.sv
// Directed bench for cv_bus_term_filt: a default-parameter instance covers
// sequencing, filtering, masking and supply drops; a small instance with a
// 2-bit counter and one-cycle filter covers saturation and clear priority.
module tb_cv_bus_term_filt;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rst, vdd, vss, clr;
  logic [1:0] in_a, mask_a;
  logic       out_a, ready_a, hit_a;
  logic [0:0] idx_a;
  logic [7:0] evt_a;

  // Small instance
  logic       rst_b, vdd_b, vss_b, clr_b;
  logic [1:0] in_b, mask_b;
  logic       out_b, ready_b, hit_b;
  logic [0:0] idx_b;
  logic [1:0] evt_b;

  int n_cmp = 0;
  int n_err = 0;

  cv_bus_term_filt dut (
    .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss), .in(in_a), .en_mask(mask_a),
    .evt_clr(clr), .out(out_a), .ready(ready_a), .hi_idx(idx_a), .hit(hit_a),
    .evt_cnt(evt_a)
  );

  cv_bus_term_filt #(.WIDTH(2), .FILT_CNT(1), .SETTLE_CYC(2), .EVT_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .VDD(vdd_b), .VSS(vss_b), .in(in_b), .en_mask(mask_b),
    .evt_clr(clr_b), .out(out_b), .ready(ready_b), .hi_idx(idx_b), .hit(hit_b),
    .evt_cnt(evt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter S_SETTLE on the first edge, ready must appear on the 8th after.
  task automatic settle_a();
    step();
    chk("settle_enter_rdy", 32'(ready_a), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("settle_rdy_%0d", i), 32'(ready_a), (i == 8) ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; vdd = 1'b0; vss = 1'b1; clr = 1'b0; in_a = 2'b00; mask_a = 2'b11;
    rst_b = 1'b1; vdd_b = 1'b0; vss_b = 1'b1; clr_b = 1'b0; in_b = 2'b00; mask_b = 2'b11;
    step(); step();
    chk("rst_out", 32'(out_a), 0);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_hit", 32'(hit_a), 0);
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_evt", 32'(evt_a), 0);

    // Power-up sequencing
    rst = 1'b0; vdd = 1'b1; vss = 1'b0;
    settle_a();
    chk("pwr_out", 32'(out_a), 0);
    chk("pwr_evt", 32'(evt_a), 0);

    // Rising edge through the filter
    in_a = 2'b01; mask_a = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("rise_out_%0d", i), 32'(out_a), (i == 4) ? 1 : 0);
    end
    chk("rise_hit", 32'(hit_a), 1);
    chk("rise_idx", 32'(idx_a), 0);
    chk("rise_evt", 32'(evt_a), 1);

    // Falling edge back to 0
    in_a = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("fall_out_%0d", i), 32'(out_a), (i == 4) ? 0 : 1);
    end
    chk("fall_evt", 32'(evt_a), 2);

    // Three-cycle glitch is rejected
    in_a = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("glitch_out_%0d", i), 32'(out_a), 0);
      chk($sformatf("glitch_idx_%0d", i), 32'(idx_a), 1);
    end
    in_a = 2'b00;
    step();
    chk("glitch_end_out", 32'(out_a), 0);
    chk("glitch_end_idx", 32'(idx_a), 0);
    chk("glitch_end_hit", 32'(hit_a), 0);
    step();
    chk("glitch_after_out", 32'(out_a), 0);
    chk("glitch_evt", 32'(evt_a), 2);

    // Fully masked bus never asserts
    in_a = 2'b11; mask_a = 2'b00;
    for (int i = 1; i <= 10; i++) step();
    chk("mask_out", 32'(out_a), 0);
    chk("mask_hit", 32'(hit_a), 0);
    mask_a = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("unmask_out_%0d", i), 32'(out_a), (i == 4) ? 1 : 0);
    end
    chk("unmask_idx", 32'(idx_a), 1);
    chk("unmask_evt", 32'(evt_a), 3);

    // Supply drop with out high
    vss = 1'b1;
    step();
    chk("drop_out", 32'(out_a), 0);
    chk("drop_ready", 32'(ready_a), 0);
    chk("drop_hit", 32'(hit_a), 0);
    chk("drop_idx", 32'(idx_a), 0);
    chk("drop_evt", 32'(evt_a), 3);
    vss = 1'b0;
    settle_a();
    chk("restore_evt", 32'(evt_a), 3);

    // Mask change mid-filter discards the partial run
    step(); step();
    mask_a = 2'b00;
    step();
    chk("midmask_out", 32'(out_a), 0);
    mask_a = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("midmask_rise_%0d", i), 32'(out_a), (i == 4) ? 1 : 0);
    end
    chk("midmask_evt", 32'(evt_a), 4);

    // Reset mid-settle restarts the whole settle period
    vss = 1'b1; step();
    vss = 1'b0; step();
    for (int i = 1; i <= 4; i++) step();
    chk("midsettle_pre_rdy", 32'(ready_a), 0);
    rst = 1'b1;
    step();
    chk("midsettle_rst_rdy", 32'(ready_a), 0);
    chk("midsettle_rst_evt", 32'(evt_a), 0);
    rst = 1'b0;
    settle_a();

    // Small instance: quick sequencing
    rst_b = 1'b0; vdd_b = 1'b1; vss_b = 1'b0;
    step();
    chk("b_enter_rdy", 32'(ready_b), 0);
    step();
    chk("b_settle_rdy", 32'(ready_b), 0);
    step();
    chk("b_on_rdy", 32'(ready_b), 1);

    // Five toggles saturate the 2-bit counter at 3
    for (int i = 1; i <= 5; i++) begin
      in_b = (i % 2 == 1) ? 2'b01 : 2'b00;
      step();
      chk($sformatf("b_tog_out_%0d", i), 32'(out_b), (i % 2 == 1) ? 1 : 0);
      chk($sformatf("b_tog_evt_%0d", i), 32'(evt_b), (i >= 3) ? 3 : i);
    end

    // Clear on a toggle edge wins
    in_b = 2'b00; clr_b = 1'b1;
    step();
    chk("b_clr_out", 32'(out_b), 0);
    chk("b_clr_evt", 32'(evt_b), 0);
    clr_b = 1'b0; in_b = 2'b10;
    step();
    chk("b_post_clr_evt", 32'(evt_b), 1);
    chk("b_post_clr_idx", 32'(idx_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
